// File: rtl/key_expand_ctrl.sv
// AES-128 key-schedule sequencer: streams w[0..43] over a valid/ready beat interface,
// using an external combinational S-box and rcon stage.
module key_expand_ctrl #(
   parameter int unsigned NWORDS = 44,
   parameter int unsigned NK     = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   output logic         start_ready,
   input  logic [127:0] key_in,
   output logic         word_valid,
   input  logic         word_ready,
   output logic [31:0]  word_data,
   output logic [5:0]   word_index,
   output logic         busy,
   output logic         done,
   output logic [31:0]  sub_in,
   input  logic [31:0]  sub_out,
   output logic [31:0]  rcon_in,
   output logic [3:0]   rcon_round,
   input  logic [31:0]  rcon_out
);

   typedef enum logic [1:0] {StIdle, StEmit, StDone} state_e;

   localparam logic [5:0] LastIdx  = 6'(NWORDS - 1);
   localparam logic [5:0] FirstGen = 6'(NK - 1);
   localparam logic [5:0] LastRcon = 6'(NWORDS - 5);
   localparam logic [5:0] NkIdx    = 6'(NK);

   state_e      state_q, state_d;
   logic [31:0] win_q [NK];
   logic [31:0] win_d [NK];
   logic [31:0] word_q, word_d;
   logic [5:0]  idx_q, idx_d;
   logic [5:0]  next_idx;
   logic [31:0] new_word;

   assign next_idx = idx_q + 6'd1;

   // win_q[NK-1] is the most recent word once generation has begun.
   assign sub_in  = {win_q[NK-1][23:0], win_q[NK-1][31:24]};
   assign rcon_in = sub_out;

   always_comb begin
      rcon_round = 4'd0;
      if (idx_q >= FirstGen && idx_q <= LastRcon) begin
         rcon_round = next_idx[5:2] - 4'd1;
      end
   end

   assign new_word = (next_idx[1:0] == 2'b00) ? (win_q[0] ^ rcon_out)
                                              : (win_q[0] ^ win_q[NK-1]);

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      word_d  = word_q;
      idx_d   = idx_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               for (int k = 0; k < NK; k++) begin
                  win_d[k] = key_in[127-32*k -: 32];
               end
               word_d  = key_in[127:96];
               idx_d   = 6'd0;
               state_d = StEmit;
            end
         end
         StEmit: begin
            if (word_ready) begin
               if (idx_q == LastIdx) begin
                  state_d = StDone;
               end else begin
                  idx_d = next_idx;
                  if (next_idx < NkIdx) begin
                     // Key words are replayed from the window without shifting.
                     word_d = win_q[next_idx[1:0]];
                  end else begin
                     word_d = new_word;
                     for (int k = 0; k < NK - 1; k++) begin
                        win_d[k] = win_q[k+1];
                     end
                     win_d[NK-1] = new_word;
                  end
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         word_q  <= 32'd0;
         idx_q   <= 6'd0;
         for (int k = 0; k < NK; k++) begin
            win_q[k] <= 32'd0;
         end
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
         win_q   <= win_d;
      end
   end

   assign start_ready = (state_q == StIdle);
   assign word_valid  = (state_q == StEmit);
   assign busy        = (state_q == StEmit);
   assign done        = (state_q == StDone);
   assign word_data   = word_q;
   assign word_index  = idx_q;

endmodule

// File: tb/tb_key_expand_ctrl.sv
// Directed bench for key_expand_ctrl; supplies the S-box and rcon stages and a
// reference key expansion, plus FIPS-197 constants.
module tb_key_expand_ctrl;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         start_ready;
   logic [127:0] key_in = '0;
   logic         word_valid;
   logic         word_ready = 1'b1;
   logic [31:0]  word_data;
   logic [5:0]   word_index;
   logic         busy;
   logic         done;
   logic [31:0]  sub_in;
   logic [31:0]  sub_out;
   logic [31:0]  rcon_in;
   logic [3:0]   rcon_round;
   logic [31:0]  rcon_out;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] ref_w [44];
   logic [31:0] got_w [44];

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic logic [7:0] sb(input logic [7:0] b);
      return SBOX[2047 - 8*int'(b) -: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
   endfunction

   function automatic logic [7:0] rc(input logic [3:0] r);
      case (r)
         4'd0: return 8'h01;
         4'd1: return 8'h02;
         4'd2: return 8'h04;
         4'd3: return 8'h08;
         4'd4: return 8'h10;
         4'd5: return 8'h20;
         4'd6: return 8'h40;
         4'd7: return 8'h80;
         4'd8: return 8'h1b;
         4'd9: return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   always_comb sub_out  = sub_word(sub_in);
   always_comb rcon_out = rcon_in ^ {rc(rcon_round), 24'h0};

   always #5 clk = ~clk;

   key_expand_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .start_ready(start_ready),
      .key_in     (key_in),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .word_data  (word_data),
      .word_index (word_index),
      .busy       (busy),
      .done       (done),
      .sub_in     (sub_in),
      .sub_out    (sub_out),
      .rcon_in    (rcon_in),
      .rcon_round (rcon_round),
      .rcon_out   (rcon_out)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic compute_ref(input logic [127:0] key);
      logic [31:0] t;
      for (int i = 0; i < 4; i++) ref_w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = ref_w[i-1];
         if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rc(4'(i/4 - 1)), 24'h0};
         ref_w[i] = ref_w[i-4] ^ t;
      end
   endtask

   // Called at a negedge; returns at the negedge where start_ready is back.
   task automatic run_stream(input logic [127:0] key, input bit rand_ready, input bit poke);
      int e = 0;
      int cyc = 1;
      compute_ref(key);
      start      = 1'b1;
      key_in     = key;
      word_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (e < 44 && cyc < 400) begin
         chk("word_valid", 64'(word_valid), 64'd1);
         chk("busy", 64'(busy), 64'd1);
         chk("done_early", 64'(done), 64'd0);
         chk("start_ready_busy", 64'(start_ready), 64'd0);
         chk("word_index", 64'(word_index), 64'(e));
         chk("word_data", 64'(word_data), 64'(ref_w[e]));
         if (!rand_ready) chk("cycle", 64'(cyc), 64'(e + 1));
         if (e % 4 == 3 && e < 40) begin
            chk("rcon_round", 64'(rcon_round), 64'((e + 1) / 4 - 1));
            chk("sub_in", 64'(sub_in), 64'({ref_w[e][23:0], ref_w[e][31:24]}));
         end
         start  = poke && (e == 10);
         key_in = poke ? ~key : key;
         word_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (word_ready) begin
            got_w[e] = word_data;
            e++;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      chk("stream_timeout", 64'(e), 64'd44);
      if (!rand_ready) chk("done_cycle", 64'(cyc), 64'd45);
      chk("done_pulse", 64'(done), 64'd1);
      chk("valid_after", 64'(word_valid), 64'd0);
      chk("busy_after", 64'(busy), 64'd0);
      chk("start_ready_done", 64'(start_ready), 64'd0);
      @(negedge clk);
      chk("done_clear", 64'(done), 64'd0);
      chk("start_ready_again", 64'(start_ready), 64'd1);
   endtask

   initial begin
      int guard;
      #1;
      chk("rst_start_ready", 64'(start_ready), 64'd1);
      chk("rst_valid", 64'(word_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_data", 64'(word_data), 64'd0);
      chk("rst_index", 64'(word_index), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_stream(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1'b0);
      chk("fips_w4", 64'(got_w[4]), 64'h a0fafe17);
      chk("fips_w5", 64'(got_w[5]), 64'h88542cb1);
      chk("fips_w6", 64'(got_w[6]), 64'h23a33939);
      chk("fips_w7", 64'(got_w[7]), 64'h2a6c7605);
      chk("fips_w40", 64'(got_w[40]), 64'hd014f9a8);
      chk("fips_w41", 64'(got_w[41]), 64'hc9ee2589);
      chk("fips_w42", 64'(got_w[42]), 64'he13f0cc8);
      chk("fips_w43", 64'(got_w[43]), 64'hb6630ca6);

      @(negedge clk);
      run_stream(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1, 1'b0);
      chk("rand_w43", 64'(got_w[43]), 64'hb6630ca6);

      @(negedge clk);
      run_stream(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1'b1);
      chk("poke_w43", 64'(got_w[43]), 64'hb6630ca6);

      // Abort mid-stream with an asynchronous reset.
      @(negedge clk);
      start  = 1'b1;
      key_in = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      word_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (word_index != 6'd20 && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      chk("reach_w20", 64'(word_index), 64'd20);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(word_valid), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_done", 64'(done), 64'd0);
      chk("arst_data", 64'(word_data), 64'd0);
      chk("arst_index", 64'(word_index), 64'd0);
      chk("arst_start_ready", 64'(start_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_stream(128'h0, 1'b0, 1'b0);
      chk("zero_w4", 64'(got_w[4]), 64'h62636363);
      chk("zero_w43", 64'(got_w[43]), 64'h6f8f188e);

      // Back-to-back: start in the first IDLE cycle after done.
      run_stream(128'h000102030405060708090a0b0c0d0e0f, 1'b0, 1'b0);
      chk("b2b_w4", 64'(got_w[4]), 64'hd6aa74fd);
      chk("b2b_w43", 64'(got_w[43]), 64'h4d2b30c5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
